// File: rtl/aemb_dwb_arbiter_if.sv
// Two-master data Wishbone bundle around the aemb_dwb_arbiter.
// slave: arbiter side; master: requesters plus system slave side.
interface aemb_dwb_arbiter_if #(
  parameter int AW = 30
);
  logic          m0_stb_i;
  logic          m0_wre_i;
  logic [AW-1:0] m0_adr_i;
  logic [3:0]    m0_sel_i;
  logic [31:0]   m0_dat_i;
  logic [31:0]   m0_dat_o;
  logic          m0_ack_o;
  logic          m0_err_o;

  logic          m1_stb_i;
  logic          m1_wre_i;
  logic [AW-1:0] m1_adr_i;
  logic [3:0]    m1_sel_i;
  logic [31:0]   m1_dat_i;
  logic [31:0]   m1_dat_o;
  logic          m1_ack_o;
  logic          m1_err_o;

  logic          s_stb_o;
  logic          s_wre_o;
  logic [AW-1:0] s_adr_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_dat_o;
  logic [31:0]   s_dat_i;
  logic          s_ack_i;

  logic [1:0]    gnt_o;
  logic          tmo_o;

  modport slave (
    input  m0_stb_i, m0_wre_i, m0_adr_i, m0_sel_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_stb_i, m1_wre_i, m1_adr_i, m1_sel_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_stb_o, s_wre_o, s_adr_o, s_sel_o, s_dat_o,
    input  s_dat_i, s_ack_i,
    output gnt_o, tmo_o
  );

  modport master (
    output m0_stb_i, m0_wre_i, m0_adr_i, m0_sel_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_stb_i, m1_wre_i, m1_adr_i, m1_sel_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_stb_o, s_wre_o, s_adr_o, s_sel_o, s_dat_o,
    output s_dat_i, s_ack_i,
    input  gnt_o, tmo_o
  );
endinterface

// File: rtl/aemb_dwb_arbiter.sv
// Round-robin two-master data Wishbone arbiter with bus timeout.
// Ports: gclk, grst (sync, active-high), bus (aemb_dwb_arbiter_if.slave).
module aemb_dwb_arbiter #(
  parameter int AW  = 30,
  parameter int TMO = 15
) (
  input logic gclk,
  input logic grst,
  aemb_dwb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);
  localparam bit         TMO_EN = (TMO != 0);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic g0, g1;
  logic req;
  logic hit;

  assign g0  = (state_q == BUS0);
  assign g1  = (state_q == BUS1);
  assign req = (g0 & bus.m0_stb_i)
             | (g1 & bus.m1_stb_i);

  // A live request that reached the wait limit
  // without ack; a same-cycle ack wins.
  assign hit = TMO_EN & req & ~bus.s_ack_i
             & (cnt_q == TMO_C);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // last_q=1 means M1 was served last,
        // so M0 wins a tie.
        if (bus.m0_stb_i &&
            (!bus.m1_stb_i || last_q)) begin
          state_d = BUS0;
          last_d  = 1'b0;
          cnt_d   = 8'd0;
        end else if (bus.m1_stb_i) begin
          state_d = BUS1;
          last_d  = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      BUS0, BUS1: begin
        // Ack, abort or timeout all end the
        // transfer with one IDLE turnaround.
        if (!req || bus.s_ack_i || hit) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt_o = {g1, g0};
  assign bus.tmo_o = hit;

  assign bus.s_stb_o = req & ~hit;
  assign bus.s_wre_o = g0 ? bus.m0_wre_i
                     : g1 ? bus.m1_wre_i
                     : 1'b0;
  assign bus.s_adr_o = g0 ? bus.m0_adr_i
                     : g1 ? bus.m1_adr_i
                     : '0;
  assign bus.s_sel_o = g0 ? bus.m0_sel_i
                     : g1 ? bus.m1_sel_i
                     : 4'd0;
  assign bus.s_dat_o = g0 ? bus.m0_dat_i
                     : g1 ? bus.m1_dat_i
                     : 32'd0;

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

  assign bus.m0_ack_o = bus.s_ack_i & g0;
  assign bus.m1_ack_o = bus.s_ack_i & g1;
  assign bus.m0_err_o = hit & g0;
  assign bus.m1_err_o = hit & g1;

endmodule

// File: tb/tb_aemb_dwb_arbiter.sv
// Directed bench for aemb_dwb_arbiter with a
// termination scoreboard.
module tb_aemb_dwb_arbiter;
  localparam int AW = 30;

  logic gclk = 1'b0;
  logic grst;
  always #5 gclk = ~gclk;

  aemb_dwb_arbiter_if #(.AW(AW)) bus();

  aemb_dwb_arbiter #(
    .AW(AW),
    .TMO(15)
  ) dut (
    .gclk(gclk),
    .grst(grst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic        m;
    logic        err;
    logic [31:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge gclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    bus.m0_stb_i = 0; bus.m0_wre_i = 0;
    bus.m0_adr_i = '0; bus.m0_sel_i = 0;
    bus.m0_dat_i = 0;
    bus.m1_stb_i = 0; bus.m1_wre_i = 0;
    bus.m1_adr_i = '0; bus.m1_sel_i = 0;
    bus.m1_dat_i = 0;
    bus.s_dat_i = 0; bus.s_ack_i = 0;
  endtask

  task automatic do_reset();
    clr();
    grst = 1;
    cyc();
    cyc();
    grst = 0;
  endtask

  // Scoreboard side: every ack/err termination
  // pops one expected event.
  always @(negedge gclk) begin
    logic a0, a1, e0, e1;
    ev_t  ob, ex;
    a0 = bus.m0_ack_o; a1 = bus.m1_ack_o;
    e0 = bus.m0_err_o; e1 = bus.m1_err_o;
    tests++;
    assert (bus.gnt_o !== 2'b11) else begin
      fails++;
      $error("FAIL gnt_onehot observed=%b expected=not 11",
             bus.gnt_o);
    end
    if (a0 | a1 | e0 | e1) begin
      tests++;
      assert (!(a0 && e0) && !(a1 && e1) &&
              !((a0 | e0) && (a1 | e1))) else begin
        fails++;
        $error("FAIL term_excl observed=%b%b%b%b expected=one",
               a0, e0, a1, e1);
      end
      ob.m   = a1 | e1;
      ob.err = e0 | e1;
      ob.dat = (a1 | e1) ? bus.m1_dat_o : bus.m0_dat_o;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected observed=%0h expected=none",
               ob);
      end else begin
        ex = exp_q.pop_front();
        tests++;
        assert (ob === ex) else begin
          fails++;
          $error("FAIL sb_term observed=%0h expected=%0h",
                 ob, ex);
        end
      end
    end
  end

  initial begin
    do_reset();
    settle();
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_stb", bus.s_stb_o, 0);
    chk("rst_tmo", bus.tmo_o, 0);

    // T1: single M0 read, zero-wait slave
    cyc();
    bus.m0_stb_i = 1; bus.m0_adr_i = 30'h100;
    bus.m0_sel_i = 4'hf;
    exp_q.push_back(ev_t'{m: 0, err: 0, dat: 32'hDEADBEEF});
    settle();
    chk("t1_req_gnt", bus.gnt_o, 0);
    chk("t1_req_stb", bus.s_stb_o, 0);
    cyc();
    bus.s_ack_i = 1; bus.s_dat_i = 32'hDEADBEEF;
    settle();
    chk("t1_gnt", bus.gnt_o, 2'b01);
    chk("t1_stb", bus.s_stb_o, 1);
    chk("t1_adr", bus.s_adr_o, 30'h100);
    chk("t1_ack", bus.m0_ack_o, 1);
    chk("t1_dat", bus.m0_dat_o, 32'hDEADBEEF);
    cyc();
    bus.m0_stb_i = 0; bus.s_ack_i = 0; bus.s_dat_i = 0;
    settle();
    chk("t1_idle", bus.gnt_o, 0);

    // T2: contention, alternating M0/M1
    do_reset();
    bus.m0_stb_i = 1; bus.m0_adr_i = 30'h200;
    bus.m1_stb_i = 1; bus.m1_adr_i = 30'h300;
    bus.s_ack_i = 1;
    for (int i = 0; i < 8; i++) begin
      bus.s_dat_i = 32'h5A5A0000 + i;
      if (i % 2 == 1)
        exp_q.push_back(ev_t'{m: 1'(i % 4 == 3), err: 0,
                              dat: 32'h5A5A0000 + i});
      settle();
      chk($sformatf("t2_gnt%0d", i), bus.gnt_o,
          (i % 2 == 0) ? 2'b00 :
          (i % 4 == 1) ? 2'b01 : 2'b10);
      if (i % 2 == 1)
        chk($sformatf("t2_adr%0d", i), bus.s_adr_o,
            (i % 4 == 1) ? 30'h200 : 30'h300);
      cyc();
    end
    bus.m0_stb_i = 0; bus.m1_stb_i = 0;
    bus.s_ack_i = 0; bus.s_dat_i = 0;
    settle();
    chk("t2_idle", bus.gnt_o, 0);

    // T3: M1 write, 3 wait states, M0 stalls
    cyc();
    bus.m1_stb_i = 1; bus.m1_wre_i = 1;
    bus.m1_adr_i = 30'h0ABCDE; bus.m1_sel_i = 4'b0011;
    bus.m1_dat_i = 32'h12345678;
    exp_q.push_back(ev_t'{m: 1, err: 0, dat: 32'h0});
    settle();
    chk("t3_req_gnt", bus.gnt_o, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 1) begin
        bus.m0_stb_i = 1; bus.m0_adr_i = 30'h111;
        bus.m0_sel_i = 4'hf; bus.m0_wre_i = 0;
        exp_q.push_back(ev_t'{m: 0, err: 0,
                              dat: 32'hCAFE0001});
      end
      bus.s_ack_i = (k == 4);
      settle();
      chk($sformatf("t3_gnt%0d", k), bus.gnt_o, 2'b10);
      chk($sformatf("t3_stb%0d", k), bus.s_stb_o, 1);
      chk($sformatf("t3_wre%0d", k), bus.s_wre_o, 1);
      chk($sformatf("t3_adr%0d", k), bus.s_adr_o, 30'h0ABCDE);
      chk($sformatf("t3_sel%0d", k), bus.s_sel_o, 4'b0011);
      chk($sformatf("t3_wdat%0d", k), bus.s_dat_o, 32'h12345678);
      chk($sformatf("t3_ack1_%0d", k), bus.m1_ack_o, (k == 4));
      chk($sformatf("t3_ack0_%0d", k), bus.m0_ack_o, 0);
      chk($sformatf("t3_err0_%0d", k), bus.m0_err_o, 0);
    end
    cyc();
    bus.m1_stb_i = 0; bus.m1_wre_i = 0; bus.s_ack_i = 0;
    settle();
    chk("t3_turn_gnt", bus.gnt_o, 0);
    chk("t3_turn_ack0", bus.m0_ack_o, 0);
    cyc();
    bus.s_ack_i = 1; bus.s_dat_i = 32'hCAFE0001;
    settle();
    chk("t3_m0_gnt", bus.gnt_o, 2'b01);
    chk("t3_m0_ack", bus.m0_ack_o, 1);
    chk("t3_m0_adr", bus.s_adr_o, 30'h111);
    cyc();
    bus.m0_stb_i = 0; bus.s_ack_i = 0; bus.s_dat_i = 0;

    // T4: timeout on the 16th BUS0 cycle
    cyc();
    bus.m0_stb_i = 1; bus.m0_adr_i = 30'h222;
    exp_q.push_back(ev_t'{m: 0, err: 1, dat: 32'h0});
    settle();
    for (int k = 1; k <= 16; k++) begin
      cyc();
      settle();
      chk($sformatf("t4_gnt%0d", k), bus.gnt_o, 2'b01);
      chk($sformatf("t4_stb%0d", k), bus.s_stb_o, (k < 16));
      chk($sformatf("t4_err%0d", k), bus.m0_err_o, (k == 16));
      chk($sformatf("t4_tmo%0d", k), bus.tmo_o, (k == 16));
      chk($sformatf("t4_ack%0d", k), bus.m0_ack_o, 0);
    end
    cyc();
    exp_q.push_back(ev_t'{m: 0, err: 0, dat: 32'hBEEF0002});
    settle();
    chk("t4_idle_gnt", bus.gnt_o, 0);
    chk("t4_idle_tmo", bus.tmo_o, 0);
    cyc();
    bus.s_ack_i = 1; bus.s_dat_i = 32'hBEEF0002;
    settle();
    chk("t4_next_gnt", bus.gnt_o, 2'b01);
    chk("t4_next_ack", bus.m0_ack_o, 1);
    chk("t4_next_err", bus.m0_err_o, 0);
    cyc();
    bus.m0_stb_i = 0; bus.s_ack_i = 0; bus.s_dat_i = 0;

    // T5: M0 abort after 2 waits, M1 pending
    cyc();
    bus.m0_stb_i = 1; bus.m0_adr_i = 30'h333;
    settle();
    cyc();
    bus.m1_stb_i = 1; bus.m1_adr_i = 30'h444;
    exp_q.push_back(ev_t'{m: 1, err: 0, dat: 32'hD00D0005});
    settle();
    chk("t5_w1_stb", bus.s_stb_o, 1);
    cyc();
    settle();
    chk("t5_w2_stb", bus.s_stb_o, 1);
    cyc();
    bus.m0_stb_i = 0;
    settle();
    chk("t5_ab_stb", bus.s_stb_o, 0);
    chk("t5_ab_gnt", bus.gnt_o, 2'b01);
    chk("t5_ab_ack", bus.m0_ack_o, 0);
    chk("t5_ab_err", bus.m0_err_o, 0);
    cyc();
    settle();
    chk("t5_idle_gnt", bus.gnt_o, 0);
    cyc();
    bus.s_ack_i = 1; bus.s_dat_i = 32'hD00D0005;
    settle();
    chk("t5_m1_gnt", bus.gnt_o, 2'b10);
    chk("t5_m1_ack", bus.m1_ack_o, 1);
    chk("t5_m1_adr", bus.s_adr_o, 30'h444);
    cyc();
    bus.m1_stb_i = 0; bus.s_ack_i = 0; bus.s_dat_i = 0;

    // T6: reset in the middle of a BUS1 transfer
    cyc();
    bus.m1_stb_i = 1; bus.m1_adr_i = 30'h555;
    bus.m1_sel_i = 4'hf;
    settle();
    cyc();
    settle();
    chk("t6_bus1_gnt", bus.gnt_o, 2'b10);
    chk("t6_bus1_stb", bus.s_stb_o, 1);
    cyc();
    grst = 1;
    settle();
    chk("t6_rstcyc_gnt", bus.gnt_o, 2'b10);
    cyc();
    grst = 0;
    bus.m0_stb_i = 1; bus.m0_adr_i = 30'h666;
    bus.s_ack_i = 1; bus.s_dat_i = 32'h0;
    settle();
    chk("t6_post_gnt", bus.gnt_o, 0);
    chk("t6_post_stb", bus.s_stb_o, 0);
    chk("t6_post_adr", bus.s_adr_o, 0);
    chk("t6_post_sel", bus.s_sel_o, 0);
    chk("t6_post_ack",
        {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o,
         bus.m1_err_o, bus.tmo_o}, 0);
    cyc();
    bus.s_dat_i = 32'h600D0006;
    exp_q.push_back(ev_t'{m: 0, err: 0, dat: 32'h600D0006});
    settle();
    chk("t6_first_gnt", bus.gnt_o, 2'b01);
    chk("t6_first_ack", bus.m0_ack_o, 1);
    cyc();
    clr();
    settle();
    chk("t6_end_gnt", bus.gnt_o, 0);
    cyc();
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
